// File: rtl/rv_mem_pkg.sv
// Shared definitions for the data-memory arbiter slice.
//   arb_state_t : arbiter FSM states (core priority / host forced)
//   WORD_W      : data word width
//   MASK_W      : byte-mask width
//   CTR_W       : width of the host wait counter
package rv_mem_pkg;

    localparam int WORD_W = 32;
    localparam int MASK_W = 4;
    localparam int CTR_W  = 8;

    typedef enum logic {
        ARB_CORE  = 1'b0,
        ARB_FORCE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle around the data-memory arbiter: core (LSU) side, host port
// side and the single data_mem port.
//   modport slave  : the arbiter itself
//   modport master : everything around it (LSU, host, data_mem)
//
// Host handshake: the host raises host_req with host_we/addr/wdata/mask and
// keeps all of them stable until it sees host_gnt high in the same cycle;
// the transfer happens at the rising edge where host_req & host_gnt. Read
// data follows one cycle later as a one-cycle host_rvalid pulse.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32
);
    import rv_mem_pkg::*;

    logic              core_cs;
    logic              core_rd;
    logic [ADDR_W-1:0] core_addr;
    logic [WORD_W-1:0] core_wdata;
    logic [MASK_W-1:0] core_mask;
    logic              core_stall;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [WORD_W-1:0] host_wdata;
    logic [MASK_W-1:0] host_mask;
    logic              host_gnt;
    logic              host_rvalid;
    logic [WORD_W-1:0] host_rdata;

    logic              mem_cs;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_mask;
    logic [WORD_W-1:0] mem_rdata;

    modport slave (
        input  core_cs, core_rd, core_addr, core_wdata, core_mask,
        output core_stall,
        input  host_req, host_we, host_addr, host_wdata, host_mask,
        output host_gnt, host_rvalid, host_rdata,
        output mem_cs, mem_rd, mem_addr, mem_wdata, mem_mask,
        input  mem_rdata
    );

    modport master (
        output core_cs, core_rd, core_addr, core_wdata, core_mask,
        input  core_stall,
        output host_req, host_we, host_addr, host_wdata, host_mask,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_cs, mem_rd, mem_addr, mem_wdata, mem_mask,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_wait_ctr.sv
// host_wait_ctr: saturating counter of cycles the host has been denied.
//   clk, reset : clock, async active-high reset
//   inc        : host requesting but not granted this cycle
//   clr        : clear (grant or no request); dominates inc
//   at_max     : the value loaded at the coming edge equals MAX_WAIT
module host_wait_ctr
    import rv_mem_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [CTR_W-1:0] MAX_V = CTR_W'(MAX_WAIT);

    logic [CTR_W-1:0] count;
    logic [CTR_W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = '0;
        end else if (inc) begin
            count_next = (count >= MAX_V) ? MAX_V : count + 1'b1;
        end
    end

    // Look-ahead so the FSM can enter ARB_FORCE on the same edge the
    // counter reaches MAX_WAIT.
    assign at_max = (count_next == MAX_V);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: single-port data-memory arbiter between the LSU (core) and
// an external host port. Core has priority; after MAX_WAIT denied host
// cycles the host is forced onto the port for one cycle and the core stalls.
//   clk, reset : clock, async active-high reset
//   bus        : dmem_arbiter_if.slave (core, host and data_mem signals)
//   state      : current arbiter FSM state (debug visibility)
module dmem_arbiter
    import rv_mem_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int ADDR_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    dmem_arbiter_if.slave      bus,
    output arb_state_t         state
);

    logic              host_gnt;
    logic              core_stall;
    logic              ctr_inc;
    logic              ctr_at_max;
    logic              host_rvalid;
    logic [WORD_W-1:0] host_rdata;
    logic [ADDR_W-1:0] mux_addr;

    // Grant and stall are combinational; both are masked while in reset.
    always_comb begin
        host_gnt   = 1'b0;
        core_stall = 1'b0;
        if (!reset) begin
            if (state == ARB_FORCE) begin
                host_gnt   = bus.host_req;
                core_stall = bus.host_req & bus.core_cs;
            end else begin
                host_gnt   = bus.host_req & ~bus.core_cs;
            end
        end
    end

    assign bus.host_gnt   = host_gnt;
    assign bus.core_stall = core_stall;

    // Single memory port mux.
    always_comb begin
        if (host_gnt) begin
            bus.mem_cs    = 1'b1;
            bus.mem_rd    = ~bus.host_we;
            mux_addr      = bus.host_addr;
            bus.mem_wdata = bus.host_wdata;
            bus.mem_mask  = bus.host_mask;
        end else begin
            bus.mem_cs    = bus.core_cs;
            bus.mem_rd    = bus.core_rd;
            mux_addr      = bus.core_addr;
            bus.mem_wdata = bus.core_wdata;
            bus.mem_mask  = bus.core_mask;
        end
    end

    assign bus.mem_addr = mux_addr;

    // Counter counts only blocked-request cycles; a grant or a dropped
    // request both restart it from zero.
    assign ctr_inc = bus.host_req & ~host_gnt;

    host_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk    (clk),
        .reset  (reset),
        .inc    (ctr_inc),
        .clr    (~ctr_inc),
        .at_max (ctr_at_max)
    );

    // FSM with registered host read return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ARB_CORE;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            case (state)
                ARB_CORE: begin
                    if (ctr_at_max) begin
                        state <= ARB_FORCE;
                    end
                end
                ARB_FORCE: begin
                    // Leaves on the forced grant or when the host gives up.
                    if (host_gnt || !bus.host_req) begin
                        state <= ARB_CORE;
                    end
                end
                default: state <= ARB_CORE;
            endcase

            host_rvalid <= host_gnt & ~bus.host_we;
            if (host_gnt && !bus.host_we) begin
                host_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.host_rvalid = host_rvalid;
    assign bus.host_rdata  = host_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    import rv_mem_pkg::*;

    localparam int MAX_WAIT = 4;
    localparam int ADDR_W   = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    arb_state_t state;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_arbiter #(
        .MAX_WAIT (MAX_WAIT),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .state (state)
    );

    // ---------------- data_mem model (driven by DUT mem_* port) ----------------
    logic [31:0] dmem [256];
    assign bus.mem_rdata = dmem[bus.mem_addr[9:2]];

    always @(posedge clk) begin
        if (bus.mem_cs && !bus.mem_rd) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_mask[b]) dmem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    int          checks;
    int          errors;
    int          waited;          // cycles the host has been denied so far
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
    logic [31:0] ref_mem [256];
    logic [31:0] exp_q [$];       // host read data still owed to the host
    logic        last_gnt;
    logic        obs_gnt;
    logic        obs_stall;
    logic [31:0] obs_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_core(input logic cs, input logic rd, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] m);
        bus.core_cs    = cs;
        bus.core_rd    = rd;
        bus.core_addr  = addr;
        bus.core_wdata = wd;
        bus.core_mask  = m;
    endtask

    task automatic set_host(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] m);
        bus.host_req   = req;
        bus.host_we    = we;
        bus.host_addr  = addr;
        bus.host_wdata = wd;
        bus.host_mask  = m;
    endtask

    function automatic logic [31:0] rand_addr();
        return {22'b0, 8'($urandom), 2'b00};
    endfunction

    // Called just after a falling edge with inputs already applied.
    // Rule: the host owns the port when the core is idle, or when it has
    // already been denied MAX_WAIT cycles in a row.
    task automatic run_cycle();
        logic       eg;
        logic [7:0] hi;
        logic [7:0] ci;
        #2;
        eg = bus.host_req && (!bus.core_cs || waited == MAX_WAIT);
        obs_gnt   = bus.host_gnt;
        obs_stall = bus.core_stall;
        obs_rdata = bus.mem_rdata;
        chk("host_gnt", bus.host_gnt, eg);
        chk("core_stall", bus.core_stall, eg && bus.core_cs);
        chk("state", state, (waited == MAX_WAIT) ? ARB_FORCE : ARB_CORE);
        chk("mem_cs", bus.mem_cs, eg || bus.core_cs);
        if (eg) begin
            chk("mem_rd_host", bus.mem_rd, !bus.host_we);
            chk("mem_addr_host", bus.mem_addr, bus.host_addr);
            chk("mem_wdata_host", bus.mem_wdata, bus.host_wdata);
            chk("mem_mask_host", bus.mem_mask, bus.host_mask);
        end else if (bus.core_cs) begin
            chk("mem_rd_core", bus.mem_rd, bus.core_rd);
            chk("mem_addr_core", bus.mem_addr, bus.core_addr);
            chk("mem_wdata_core", bus.mem_wdata, bus.core_wdata);
            chk("mem_mask_core", bus.mem_mask, bus.core_mask);
            if (bus.core_rd) chk("core_rdata", bus.mem_rdata, ref_mem[bus.core_addr[9:2]]);
        end
        last_gnt = eg;
        @(posedge clk);
        hi = bus.host_addr[9:2];
        ci = bus.core_addr[9:2];
        if (eg && !bus.host_we) exp_q.push_back(ref_mem[hi]);
        if (eg && bus.host_we)
            ref_mem[hi] = merge(ref_mem[hi], bus.host_wdata, bus.host_mask);
        else if (!eg && bus.core_cs && !bus.core_rd)
            ref_mem[ci] = merge(ref_mem[ci], bus.core_wdata, bus.core_mask);
        if (bus.host_req && !eg) waited = (waited < MAX_WAIT) ? waited + 1 : MAX_WAIT;
        else                     waited = 0;
        exp_rvalid = (exp_q.size() != 0);
        if (exp_rvalid) exp_rdata = exp_q.pop_front();
        @(negedge clk);
        chk("host_rvalid", bus.host_rvalid, exp_rvalid);
        chk("host_rdata", bus.host_rdata, exp_rdata);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [31:0] v;
        checks = 0;
        errors = 0;
        waited = 0;
        exp_rvalid = 1'b0;
        exp_rdata  = '0;
        last_gnt   = 1'b0;
        reset = 1'b1;
        set_core(1'b1, 1'b1, 32'h0, 32'h0, 4'h0);
        set_host(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            dmem[i]    <= v;
            ref_mem[i]  = v;
        end
        dmem[4]    <= 32'hDEADBEEF;
        ref_mem[4]  = 32'hDEADBEEF;

        // Reset values with both requesters active.
        repeat (2) @(negedge clk);
        chk("rst_gnt", bus.host_gnt, 1'b0);
        chk("rst_stall", bus.core_stall, 1'b0);
        chk("rst_rvalid", bus.host_rvalid, 1'b0);
        chk("rst_rdata", bus.host_rdata, 32'h0);
        chk("rst_state", state, ARB_CORE);
        set_core(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
        set_host(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        reset = 1'b0;

        // T1: core idle, host reads 0x10.
        set_host(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        run_cycle();
        chk("t1_gnt", obs_gnt, 1'b1);
        chk("t1_stall", obs_stall, 1'b0);
        chk("t1_rvalid", bus.host_rvalid, 1'b1);
        chk("t1_rdata", bus.host_rdata, 32'hDEADBEEF);
        set_host(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        run_cycle();

        // T2: continuous core traffic, host read waits MAX_WAIT cycles.
        set_core(1'b1, 1'b1, rand_addr(), $urandom, 4'hf);
        set_host(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            run_cycle();
            if (obs_gnt) break;
            n++;
            set_core(1'b1, 1'b1, rand_addr(), $urandom, 4'hf);
        end
        chk("t2_wait", n, 4);
        chk("t2_stall", obs_stall, 1'b1);
        set_host(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        run_cycle();
        chk("t2_core_back", obs_stall, 1'b0);

        // T3: host write during core idle, then core reads it back.
        set_core(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
        set_host(1'b1, 1'b1, 32'h20, 32'h12345678, 4'hf);
        run_cycle();
        chk("t3_rvalid", bus.host_rvalid, 1'b0);
        set_host(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_core(1'b1, 1'b1, 32'h20, 32'h0, 4'h0);
        run_cycle();
        chk("t3_core_rd", obs_rdata, 32'h12345678);

        // T4: host drops after 2 blocked cycles, then re-requests.
        set_core(1'b1, 1'b1, rand_addr(), 32'h0, 4'h0);
        set_host(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
        run_cycle();
        run_cycle();
        set_host(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        run_cycle();
        set_host(1'b1, 1'b0, 32'h34, 32'h0, 4'h0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            run_cycle();
            if (obs_gnt) break;
            n++;
        end
        chk("t4_wait", n, 4);
        set_host(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        run_cycle();

        // T5: reset pulsed the cycle after a host read grant.
        set_core(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
        set_host(1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
        run_cycle();
        chk("t5_rvalid_pre", bus.host_rvalid, 1'b1);
        set_host(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rvalid", bus.host_rvalid, 1'b0);
        chk("t5_rdata", bus.host_rdata, 32'h0);
        chk("t5_state", state, ARB_CORE);
        exp_rvalid = 1'b0;
        exp_rdata  = '0;
        waited     = 0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        set_core(1'b1, 1'b1, rand_addr(), 32'h0, 4'h0);
        set_host(1'b1, 1'b0, 32'h48, 32'h0, 4'h0);
        run_cycle();
        chk("t5_no_stall", obs_stall, 1'b0);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) < 80)
                set_core(1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom));
            else
                set_core(1'b0, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom));
            if (!bus.host_req || last_gnt) begin
                if ($urandom_range(0, 1) == 1)
                    set_host(1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom));
                else
                    set_host(1'b0, 1'b0, rand_addr(), $urandom, 4'h0);
            end else if ($urandom_range(0, 15) == 0) begin
                set_host(1'b0, 1'b0, rand_addr(), $urandom, 4'h0);
            end
            run_cycle();
        end

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
